// File: rtl/calc_scoreboard.sv
// Response scoreboard: per-port expected FIFOs, in-order compare,
// sticky error flags and a pass/fail verdict at each test boundary.
module calc_scoreboard #(
    parameter int NPORTS  = 4,
    parameter int DATA_W  = 32,
    parameter int RESP_W  = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                     c_clk,
    input  logic                     reset,
    input  logic [NPORTS*RESP_W-1:0] ref_resp,
    input  logic [NPORTS*DATA_W-1:0] ref_data,
    input  logic [NPORTS*RESP_W-1:0] duv_resp,
    input  logic [NPORTS*DATA_W-1:0] duv_data,
    input  logic                     test_end,
    output logic [NPORTS-1:0]        match,
    output logic [NPORTS-1:0]        mismatch,
    output logic [NPORTS-1:0]        unexpected,
    output logic [NPORTS-1:0]        overflow,
    output logic [NPORTS-1:0]        timeout,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [CNT_W-1:0]         mism_cnt,
    output logic                     done,
    output logic                     pass
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int EW  = RESP_W + DATA_W;
    localparam int AGW = $clog2(TIMEOUT + 1);

    logic              te_q, done_q, pass_q, clr, ok;
    logic [CNT_W-1:0]  mcnt_q, mcnt_d, mmcnt_q, mmcnt_d;
    logic [NPORTS-1:0] emp_w;

    // te_q marks the clear/verdict cycle; state of the old test is wiped then
    assign clr = te_q;

    function automatic logic [CNT_W-1:0] sat_add(
        input logic [CNT_W-1:0]  a,
        input logic [NPORTS-1:0] v
    );
        logic [CNT_W:0] s;
        s = {1'b0, a};
        for (int i = 0; i < NPORTS; i++) begin
            s = s + {{CNT_W{1'b0}}, v[i]};
        end
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    for (genvar gp = 0; gp < NPORTS; gp++) begin : g_port
        logic [RESP_W-1:0] rr, dr, cr;
        logic [DATA_W-1:0] rd, dd, cd;
        logic              push, pop, empty, full;
        logic              we, cmp, unx, ovf, eq;
        logic [EW-1:0]     mem_q [DEPTH];
        logic [EW-1:0]     head;
        logic [PW-1:0]     wp_q, wp_d, wp_e;
        logic [PW-1:0]     rp_q, rp_d, rp_e;
        logic [AGW-1:0]    age_q, age_d, age_e;
        logic              pm_q, pmm_q, ux_q, ov_q, to_q;

        assign rr    = ref_resp[gp*RESP_W +: RESP_W];
        assign dr    = duv_resp[gp*RESP_W +: RESP_W];
        assign rd    = ref_data[gp*DATA_W +: DATA_W];
        assign dd    = duv_data[gp*DATA_W +: DATA_W];
        assign push  = |rr;
        assign pop   = |dr;
        assign wp_e  = clr ? '0 : wp_q;
        assign rp_e  = clr ? '0 : rp_q;
        assign age_e = clr ? '0 : age_q;
        assign empty = (wp_e == rp_e);
        assign full  = (wp_e[AW] != rp_e[AW])
                    && (wp_e[AW-1:0] == rp_e[AW-1:0]);
        assign head  = mem_q[rp_e[AW-1:0]];
        // empty FIFO with a same-cycle push compares against the incoming ref
        assign cr    = empty ? rr : head[EW-1 -: RESP_W];
        assign cd    = empty ? rd : head[DATA_W-1:0];
        assign eq    = (cr == dr)
                    && ((cr != RESP_W'(1)) || (cd == dd));

        // Push/pop decision and pointer next-state
        always_comb begin
            wp_d = wp_e;
            rp_d = rp_e;
            we   = 1'b0;
            cmp  = 1'b0;
            unx  = 1'b0;
            ovf  = 1'b0;
            if (pop) begin
                if (empty) begin
                    cmp = push;
                    unx = !push;
                end else begin
                    cmp  = 1'b1;
                    rp_d = rp_e + 1'b1;
                    if (push) begin
                        we   = 1'b1;
                        wp_d = wp_e + 1'b1;
                    end
                end
            end else if (push) begin
                if (full) begin
                    ovf = 1'b1;
                end else begin
                    we   = 1'b1;
                    wp_d = wp_e + 1'b1;
                end
            end
        end

        // Head age: reset by a pop or an empty FIFO, saturates at TIMEOUT
        always_comb begin
            age_d = age_e;
            if (pop || empty) begin
                age_d = '0;
            end else if (age_e != AGW'(TIMEOUT)) begin
                age_d = age_e + 1'b1;
            end
        end

        // Expected-entry storage, no reset needed behind the pointers
        always_ff @(posedge c_clk) begin
            if (we) begin
                mem_q[wp_e[AW-1:0]] <= {rr, rd};
            end
        end

        // Per-port pointers, age, pulses and sticky flags
        always_ff @(posedge c_clk or negedge reset) begin
            if (!reset) begin
                wp_q  <= '0;
                rp_q  <= '0;
                age_q <= '0;
                pm_q  <= 1'b0;
                pmm_q <= 1'b0;
                ux_q  <= 1'b0;
                ov_q  <= 1'b0;
                to_q  <= 1'b0;
            end else begin
                wp_q  <= wp_d;
                rp_q  <= rp_d;
                age_q <= age_d;
                pm_q  <= cmp && eq;
                pmm_q <= (cmp && !eq) || unx;
                ux_q  <= (ux_q && !clr) || unx;
                ov_q  <= (ov_q && !clr) || ovf;
                to_q  <= (to_q && !clr) || (age_d == AGW'(TIMEOUT));
            end
        end

        assign match[gp]      = pm_q;
        assign mismatch[gp]   = pmm_q;
        assign unexpected[gp] = ux_q;
        assign overflow[gp]   = ov_q;
        assign timeout[gp]    = to_q;
        assign emp_w[gp]      = (wp_q == rp_q);
    end

    // Verdict uses pre-clear state, including pulses still in flight
    assign ok = (mmcnt_q == '0) && (mismatch == '0)
             && !(|{unexpected, overflow, timeout})
             && (&emp_w);

    // Totals: add this cycle's pulses, restart at the test boundary
    always_comb begin
        mcnt_d  = clr ? '0 : sat_add(mcnt_q, match);
        mmcnt_d = clr ? '0 : sat_add(mmcnt_q, mismatch);
    end

    // Test boundary sequencing and counters
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            te_q    <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mcnt_q  <= '0;
            mmcnt_q <= '0;
        end else begin
            te_q    <= test_end && !te_q;
            done_q  <= te_q;
            pass_q  <= te_q && ok;
            mcnt_q  <= mcnt_d;
            mmcnt_q <= mmcnt_d;
        end
    end

    assign match_cnt = mcnt_q;
    assign mism_cnt  = mmcnt_q;
    assign done      = done_q;
    assign pass      = pass_q;
endmodule

// File: tb/tb_calc_scoreboard.sv
// Directed bench for calc_scoreboard: vector table plus
// hand sequences for timeout, async reset, back-to-back and saturation.
module tb_calc_scoreboard;
    logic         c_clk = 1'b0;
    logic         reset;
    logic [7:0]   ref_resp, duv_resp;
    logic [127:0] ref_data, duv_data;
    logic         test_end;
    logic [3:0]   match, mismatch, unexpected, overflow, timeout;
    logic [15:0]  match_cnt, mism_cnt;
    logic         done, pass;

    int ntests = 0;
    int nfail  = 0;
    int dcnt;

    typedef struct {
        int          port;
        logic [1:0]  rr;
        logic [31:0] rd;
        logic [1:0]  dr;
        logic [31:0] dd;
        logic        te;
        logic [3:0]  m, mm, ux, ov;
        logic [15:0] mc, mmc;
        logic        dn, ps;
    } vec_t;

    vec_t vq[$];

    calc_scoreboard dut (
        .c_clk(c_clk), .reset(reset),
        .ref_resp(ref_resp), .ref_data(ref_data),
        .duv_resp(duv_resp), .duv_data(duv_data),
        .test_end(test_end),
        .match(match), .mismatch(mismatch),
        .unexpected(unexpected), .overflow(overflow),
        .timeout(timeout),
        .match_cnt(match_cnt), .mism_cnt(mism_cnt),
        .done(done), .pass(pass)
    );

    always #5 c_clk = ~c_clk;

    function automatic logic [63:0] outs();
        return {10'b0, match, mismatch, unexpected, overflow, timeout,
                match_cnt, mism_cnt, done, pass};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input int port, input logic [1:0] rr,
                       input logic [31:0] rd, input logic [1:0] dr,
                       input logic [31:0] dd, input logic te,
                       input logic [3:0] m, input logic [3:0] mm,
                       input logic [3:0] ux, input logic [3:0] ov,
                       input logic [15:0] mc, input logic [15:0] mmc,
                       input logic dn, input logic ps);
        vec_t t;
        t.port = port; t.rr = rr; t.rd = rd; t.dr = dr; t.dd = dd;
        t.te = te; t.m = m; t.mm = mm; t.ux = ux; t.ov = ov;
        t.mc = mc; t.mmc = mmc; t.dn = dn; t.ps = ps;
        vq.push_back(t);
    endtask

    task automatic idle_row(input logic [15:0] mc, input logic [15:0] mmc,
                            input logic dn, input logic ps);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, mc, mmc, dn, ps);
    endtask

    task automatic drive(input int port, input logic [1:0] rr,
                         input logic [31:0] rd, input logic [1:0] dr,
                         input logic [31:0] dd, input logic te);
        ref_resp = '0; ref_data = '0;
        duv_resp = '0; duv_data = '0;
        ref_resp[port*2 +: 2]  = rr;
        ref_data[port*32 +: 32] = rd;
        duv_resp[port*2 +: 2]  = dr;
        duv_data[port*32 +: 32] = dd;
        test_end = te;
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // port 1 match, clean test
        idle_row(0, 0, 0, 0);
        add(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_row(0, 0, 0, 0);
        idle_row(0, 0, 0, 0);
        add(1, 0, 0, 1, 5, 0, 4'b0010, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        idle_row(0, 0, 1, 1);
        idle_row(0, 0, 0, 0);
        // port 2 data mismatch
        add(2, 1, 'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(2, 0, 0, 1, 'h11, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle_row(0, 0, 1, 0);
        // port 0 overflow
        for (int i = 0; i < 4; i++) begin
            add(0, 3, i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        add(0, 3, 4, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0001, 0, 0, 0, 0);
        idle_row(0, 0, 1, 0);
        // port 3 bypass, data ignored unless resp is success
        add(3, 2, 'hAA, 2, 'hBB, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 0);
        idle_row(1, 0, 0, 0);
        add(3, 1, 7, 3, 7, 0, 0, 4'b1000, 0, 0, 1, 0, 0, 0);
        idle_row(1, 1, 0, 0);
        // unexpected on port 0
        add(0, 0, 0, 1, 0, 0, 0, 4'b0001, 4'b0001, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 4'b0001, 0, 1, 2, 0, 0);
        idle_row(0, 0, 1, 0);
        // leftover entry fails the test
        add(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_row(0, 0, 1, 0);
        // full FIFO push+pop keeps order, no overflow
        for (int i = 0; i < 4; i++) begin
            add(2, 1, 'h20 + i, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        add(2, 1, 'h24, 1, 'h20, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < 5; i++) begin
            add(2, 0, 0, 1, 'h20 + i, 0, 4'b0100, 0, 0, 0,
                16'(i), 0, 0, 0);
        end
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 5, 0, 0, 0);
        // push in the clear cycle belongs to the next test
        add(0, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 1, 9, 0, 4'b0001, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        idle_row(0, 0, 1, 1);

        repeat (2) @(posedge c_clk);
        #1 chk("reset_state", outs(), 64'd0);
        @(negedge c_clk);
        reset = 1'b1;

        foreach (vq[i]) begin
            @(negedge c_clk);
            drive(vq[i].port, vq[i].rr, vq[i].rd,
                  vq[i].dr, vq[i].dd, vq[i].te);
            @(posedge c_clk);
            #1 chk($sformatf("vec%0d", i), outs(),
                   {10'b0, vq[i].m, vq[i].mm, vq[i].ux, vq[i].ov, 4'b0,
                    vq[i].mc, vq[i].mmc, vq[i].dn, vq[i].ps});
        end

        // timeout after 64 cycles, entry still matches later
        @(negedge c_clk);
        drive(0, 1, 'h33, 0, 0, 0);
        @(posedge c_clk);
        @(negedge c_clk);
        drive(0, 0, 0, 0, 0, 0);
        repeat (63) @(posedge c_clk);
        #1 chk("tmo_age63", 64'(timeout), 64'd0);
        @(posedge c_clk);
        #1 chk("tmo_age64", 64'(timeout), 64'd1);
        @(negedge c_clk);
        drive(0, 0, 0, 1, 'h33, 0);
        @(posedge c_clk);
        #1 chk("tmo_match", 64'({match, timeout}), 64'h11);
        @(negedge c_clk);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge c_clk);
        #1 chk("tmo_sticky", 64'({match_cnt, timeout}), 64'h11);
        @(negedge c_clk);
        drive(0, 0, 0, 0, 0, 1);
        @(negedge c_clk);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge c_clk);
        #1 chk("tmo_verdict", 64'({done, pass, timeout}), 64'h20);

        // all ports match together
        @(negedge c_clk);
        for (int p = 0; p < 4; p++) begin
            ref_resp[p*2 +: 2]  = 2'd1;
            ref_data[p*32 +: 32] = 32'h100 + p;
        end
        @(negedge c_clk);
        duv_resp = ref_resp;
        duv_data = ref_data;
        ref_resp = '0;
        @(posedge c_clk);
        #1 chk("all_match", 64'(match), 64'hF);
        @(negedge c_clk);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge c_clk);
        #1 chk("all_cnt", 64'(match_cnt), 64'd4);
        @(negedge c_clk);
        #2 reset = 1'b0;
        #1 chk("async_reset", outs(), 64'd0);
        @(negedge c_clk);
        reset = 1'b1;

        // reset between test_end and done suppresses done
        @(negedge c_clk);
        test_end = 1'b1;
        @(posedge c_clk);
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        @(negedge c_clk);
        test_end = 1'b0;
        dcnt = 0;
        repeat (2) begin
            @(posedge c_clk);
            #1 dcnt += int'(done);
        end
        chk("no_done_after_reset", 64'(dcnt), 64'd0);

        // back-to-back test_end: one verdict per two cycles
        @(negedge c_clk);
        test_end = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge c_clk);
            #1 dcnt += int'(done);
            if (k == 3) test_end = 1'b0;
        end
        chk("b2b_done_count", 64'(dcnt), 64'd2);

        // counter saturation
        @(negedge c_clk);
        ref_resp = 8'hAA;
        duv_resp = 8'hAA;
        repeat (16400) @(posedge c_clk);
        @(negedge c_clk);
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge c_clk);
        #1 chk("sat_cnt", 64'({match_cnt, mism_cnt}), 64'hFFFF0000);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
